// File: rtl/row_delay_buffer.sv
// row_delay_buffer: valid-qualified fixed-depth delay buffer; each accepted beat re-emerges DEPTH accepted beats later.
// Optional feature macro ROW_DELAY_ZERO_FILL_EN: emit zero-valued beats while the buffer is still filling.
module row_delay_buffer #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  // The counter must be able to hold DEPTH itself, so it can be one bit wider than the pointer.
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_FILL, S_STREAM} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_fill_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              w_accept;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_out_valid_d;
  logic [DATA_W-1:0] w_out_data_d;

  assign w_accept  = in_valid & ~flush;
  assign w_rd_data = r_mem[r_wr_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush)
      w_next_state = S_FILL;
    else if (r_state == S_FILL && w_accept && r_fill_cnt == LAST_CNT)
      w_next_state = S_STREAM;
  end

  always_comb begin
    w_out_valid_d = 1'b0;
    w_out_data_d  = r_out_data;
    if (w_accept) begin
`ifdef ROW_DELAY_ZERO_FILL_EN
      w_out_valid_d = 1'b1;
      w_out_data_d  = (r_state == S_STREAM) ? w_rd_data : '0;
`else
      w_out_valid_d = (r_state == S_STREAM);
      w_out_data_d  = w_rd_data;
`endif
    end
  end

  // Storage is deliberately not reset; stale words are never marked valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
      end else if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        if (r_fill_cnt != FULL_CNT) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign full      = (r_state == S_STREAM);

endmodule

// File: tb/tb_row_delay_buffer.sv
// tb_row_delay_buffer: directed stimulus for row_delay_buffer with a queue-based scoreboard of delayed beats.
// A second DEPTH=2 instance shares the inputs and is checked against constants in its own step.
module tb_row_delay_buffer;

  localparam int DATA_W = 48;
  localparam int DEPTH  = 28;
`ifdef ROW_DELAY_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid, full;
  logic [DATA_W-1:0] out_data;
  logic              out_valid2, full2;
  logic [DATA_W-1:0] out_data2;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] sb[$];
  logic              expValid = 1'b0;

  row_delay_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .full(full)
  );

  row_delay_buffer #(.DATA_W(DATA_W), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid2), .out_data(out_data2), .full(full2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [DATA_W-1:0] expData;
    check("out_valid", {63'd0, out_valid}, {63'd0, expValid});
    check("full", {63'd0, full}, {63'd0, (hist.size() == DEPTH)});
    if (out_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("[TB] FAIL sb_underflow observed=0 expected=1");
      end
      if (sb.size() > 0) begin
        expData = sb.pop_front();
        check("out_data", 64'(out_data), 64'(expData));
      end
    end
  endtask

  // Drive one cycle of input, update the model, then sample #1 after the edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic f);
    @(negedge clk);
    in_valid = v; in_data = d; flush = f;
    expValid = 1'b0;
    if (f) begin
      hist.delete();
    end else if (v && rst) begin
      hist.push_back(d);
      if (hist.size() > DEPTH) begin
        sb.push_back(hist.pop_front());
        expValid = 1'b1;
      end else if (ZF) begin
        sb.push_back('0);
        expValid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    hist.delete(); sb.delete(); expValid = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_full", {63'd0, full}, 64'd0);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    $display("[TB] start DEPTH=%0d zero_fill=%0d", DEPTH, ZF);
    #2;
    check("por_out_valid", {63'd0, out_valid}, 64'd0);
    check("por_full", {63'd0, full}, 64'd0);
    check("por_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Continuous stream 1..40.
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0);
      if (i == 28) check("t1_full_after_28", {63'd0, full}, 64'd1);
      if (i == 29) check("t1_first_out", 64'(out_data), 64'd1);
      if (i == 40) check("t1_last_out", 64'(out_data), 64'd12);
    end
    applyStimulus(1'b0, '0, 1'b0);

    // Same stream with a bubble after every beat.
    doReset(1);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0);
      applyStimulus(1'b0, DATA_W'(i + 500), 1'b0);
    end
    check("t2_hold_data", 64'(out_data), 64'd12);

    // Flush colliding with a valid beat drops that beat.
    doReset(1);
    for (int i = 1; i <= 35; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0);
    applyStimulus(1'b1, DATA_W'(99), 1'b1);
    check("t3_full_after_flush", {63'd0, full}, 64'd0);
    for (int i = 100; i <= 130; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0);
      if (i == 128) check("t3_first_after_flush", 64'(out_data), 64'd100);
    end

    // Asynchronous reset in mid-stream.
    doReset(1);
    for (int i = 1; i <= 33; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0);
    doReset(3);
    for (int i = 200; i <= 230; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0);
      if (i == 228) check("t4_first_after_rst", 64'(out_data), 64'd200);
    end

    // Minimum depth instance: beats 5,6,7,8.
    doReset(1);
    for (int i = 5; i <= 8; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0);
      case (i)
        5: begin
          check("d2_valid_b5", {63'd0, out_valid2}, {63'd0, ZF});
          check("d2_full_b5", {63'd0, full2}, 64'd0);
        end
        6: begin
          check("d2_valid_b6", {63'd0, out_valid2}, {63'd0, ZF});
          check("d2_full_b6", {63'd0, full2}, 64'd1);
        end
        7: begin
          check("d2_valid_b7", {63'd0, out_valid2}, 64'd1);
          check("d2_data_b7", 64'(out_data2), 64'd5);
        end
        default: begin
          check("d2_valid_b8", {63'd0, out_valid2}, 64'd1);
          check("d2_data_b8", 64'(out_data2), 64'd6);
        end
      endcase
    end
    applyStimulus(1'b0, '0, 1'b0);
    check("d2_pulse_ends", {63'd0, out_valid2}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
